// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues single-outstanding reads to
// instruction memory over req/ack, buffers returned words with their PC in a
// small FIFO for Decode, and handles stall, branch redirect/flush and halt.
`timescale 1ns/1ps
module fetch_stage #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [DATA_W-1:0] palavra,
  output logic [ADDR_W-1:0] palavra_pc,
  output logic              palavra_valid,
  output logic              halted
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_DROP   = 2'd2;
  localparam logic [1:0] S_HALTED = 2'd3;

  localparam logic [3:0]       OP_HALT  = 4'hF;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] fifo_word [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_pc   [FIFO_DEPTH];

  logic push;
  logic pop;
  logic has_space;
  logic is_halt_word;

  assign has_space    = (count < DEPTH_C);
  assign is_halt_word = (imem_rdata[DATA_W-1 -: 4] == OP_HALT);
  assign push         = (state == S_WAIT) && imem_ack && !branch_taken;
  assign pop          = palavra_valid && !stall && !branch_taken;

  assign imem_req      = (state == S_WAIT) || (state == S_DROP);
  assign halted        = (state == S_HALTED);
  assign palavra_valid = (count != '0);
  assign palavra       = palavra_valid ? fifo_word[rd_ptr] : '0;
  assign palavra_pc    = palavra_valid ? fifo_pc[rd_ptr]   : '0;

  // Fetch FSM and PC: branch redirect overrides every state. A request still
  // outstanding at redirect time is kept alive in DROP so its ack is absorbed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc        <= '0;
      imem_addr <= '0;
    end else if (branch_taken) begin
      pc <= branch_target;
      if (((state == S_WAIT) || (state == S_DROP)) && !imem_ack)
        state <= S_DROP;
      else
        state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (has_space) begin
            imem_addr <= pc;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_ack) begin
            pc    <= pc + 1'b1;
            state <= is_halt_word ? S_HALTED : S_IDLE;
          end
        end
        S_DROP: begin
          if (imem_ack)
            state <= S_IDLE;
        end
        default: ;
      endcase
    end
  end

  // FIFO bookkeeping: pointers and occupancy; a redirect flushes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (branch_taken) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (!push && pop)
        count <= count - 1'b1;
    end
  end

  // FIFO storage: payload is gated by count on the outputs, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_word[wr_ptr] <= imem_rdata;
      fifo_pc[wr_ptr]   <= pc;
    end
  end

endmodule
